// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
//   clog2_safe : pointer width helper that never returns 0
//   FIFO_STD   : registered-read mode selector
//   FIFO_FWFT  : first-word-fall-through mode selector
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // $clog2(1) is 0, which would produce zero-width pointers.
  function automatic int clog2_safe(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage array.
// One synchronous write port and one asynchronous read port.
// The contents are not reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with the following features:
//   - programmable almost-full and almost-empty thresholds
//   - a live occupancy count
//   - a synchronous flush
//   - sticky overflow and underflow flags
//   - a selectable FWFT read mode
//
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   flush                   : clears the contents and keeps the error flags
//   err_clr                 : clears overflow and underflow
//   wr_en, din              : write request and write data
//   rd_en                   : read request (pops the head in FWFT mode)
//   dout                    : read data (registered in STD mode, head word in FWFT mode)
//   full, almost_full       : count == DEPTH, count >= AF_THRESH
//   empty, almost_empty     : count == 0, count <= AE_THRESH
//   count                   : occupancy, 0..DEPTH
//   overflow, underflow     : sticky error flags
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int AF_THRESH  = DEPTH - 2,
  parameter  int AE_THRESH  = 2,
  parameter  int FWFT       = FIFO_STD,
  localparam int ADDR_WIDTH = clog2_safe(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc, rd_acc, ovf_set, udf_set;
  logic [DATA_WIDTH-1:0] rdata;

  // Acceptance is decided from the registered flags, so a full FIFO rejects
  // a write even when a read frees a slot in the same cycle. Flush masks
  // all requests, and therefore also the error conditions.
  always_comb begin
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (!flush) begin
      wr_acc  = wr_en && !full_q;
      rd_acc  = rd_en && !empty_q;
      ovf_set = wr_en && full_q;
      udf_set = rd_en && empty_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // A set condition outranks err_clr in the same cycle.
    ovf_d = (ovf_q && !err_clr) || ovf_set;
    udf_d = (udf_q && !err_clr) || udf_set;
  end

  // The flags are derived from count_d, so they line up with count on every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      afull_q  <= (count_d >= AF_C);
      empty_q  <= (count_d == '0);
      aempty_q <= (count_d <= AE_C);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && rst_n),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // The head word is shown directly. It is meaningless while empty is high.
    assign dout = rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (!rst_n || flush) dout_q <= '0;
      else if (rd_acc)     dout_q <= rdata;
    end
    assign dout = dout_q;
  end

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO; the next generation of the team's basic synchronous FIFO.
- Adds programmable almost-full/almost-empty thresholds, a live occupancy output, a synchronous flush, and sticky overflow/underflow error flags.
- Adds a selectable first-word-fall-through (FWFT) read mode.
- Sits between any producer/consumer pair in the datapath that needs buffering with early back-pressure.

Parameters:
DATA_WIDTH, 8, word width in bits
DEPTH, 16, number of entries; power of two, >= 4
ADDR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden)
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of contents; keeps error flags
err_clr  in  1  clears overflow/underflow
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request (pop in FWFT)
dout  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
empty  out  1  count == 0
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low at posedge): wr_ptr = 0, rd_ptr = 0, count = 0, dout = 0 in standard mode, full = 0, almost_full = 0, empty = 1, almost_empty = 1, overflow = 0, underflow = 0. Memory contents are not reset.
- Reset is sampled at the clock edge only. Reset mid-transfer discards all contents; requests in the reset cycle are ignored.
- Accepted write: wr_acc = wr_en && !full. Accepted read: rd_acc = rd_en && !empty. Both use state at the start of the cycle. A write is never accepted into a full FIFO, even when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH (natural wrap).
- Accepted read: rd_ptr increments modulo DEPTH.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- All four level flags and count are registered and computed from the next-state count. They are therefore exact in the same cycle that count shows.
  - Example: with DEPTH = 16, full rises on the edge that accepts the 16th write.
- Standard mode (FWFT = 0): dout is registered, loads mem[rd_ptr] on the edge of an accepted read, valid from the next cycle. dout holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT = 1): dout = mem[rd_ptr] (combinational read of the head). Valid whenever empty = 0; undefined when empty = 1. rd_en with !empty consumes the shown word, and the next word appears in the following cycle.
- Write to empty in FWFT: the word is visible on dout in the cycle after the write edge, together with empty = 0.
- overflow is set on the edge where wr_en && full; underflow is set on the edge where rd_en && empty.
- err_clr clears both error flags. If a set condition and err_clr occur in the same cycle, set wins.
- flush (rst_n high): pointers and count go to 0 and flags take their reset values except overflow/underflow, which are unaffected. dout goes to 0 in standard mode. flush overrides wr_en/rd_en in the same cycle: no write or read is performed and no error is flagged.
- Priority: rst_n > flush > normal operation.
- Occupancy invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and the FIFO is full.

Decomposition:
- Shared package fifo_pkg: clog2-safe width helper and mode constants FIFO_STD = 0, FIFO_FWFT = 1. Reuse fifo_pkg across FIFO variants.
- One natural sub-module: fifo_mem_2p, a DEPTH x DATA_WIDTH storage array with one synchronous write port and one asynchronous read port. Standard mode registers its output in the parent.

Test Plan:
- Reset/fill (DEPTH = 16, FWFT = 0): write 0x00..0x0F on consecutive cycles.
  - almost_full rises when count = 14 and full rises when count = 16.
  - A 17th write sets overflow = 1 and count stays 16.
- Drain: 16 reads from full -> dout = 0x00..0x0F, each one cycle after its read edge. almost_empty rises at count = 2, empty rises at count = 0. A 17th read sets underflow = 1 and dout holds 0x0F.
- Wrap and simultaneous access: preload 8 words, then 40 cycles of wr_en = rd_en = 1 with an incrementing pattern -> count stays 8 and output order is preserved across pointer wrap.
- Boundary simultaneous access: at full, wr_en = rd_en = 1 -> read accepted, write rejected, count = 15, overflow = 1. At empty, both high -> write accepted, count = 1, underflow = 1.
- FWFT = 1: write 0xA5 into an empty FIFO -> next cycle empty = 0 and dout = 0xA5 with no rd_en. Write 0x3C, pulse rd_en -> dout = 0x3C the next cycle.
- Flush and error clearing:
  - flush with 5 entries and wr_en = 1 -> count = 0, empty = 1, no write stored, overflow unchanged.
  - err_clr with overflow = 1 -> overflow = 0 next cycle.
  - rst_n = 0 mid-fill -> all outputs at their reset values next cycle.
